// File: rtl/counter_mod_pkg.sv
// Shared constants and types for the modulo counter slice.
// Provides the default width/modulus/prescale values, the default count
// type, and a helper that sizes the prescaler register.
package counter_mod_pkg;

  localparam int CM_WIDTH = 4;
  localparam int CM_MOD   = 10;
  localparam int CM_DIV   = 2;

  typedef logic [CM_WIDTH-1:0] cm_count_t;

  // A divide-by-one prescaler still needs a one-bit register, because a
  // zero-width vector is not a legal declaration.
  function automatic int cm_prescale_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable prescaler: produces a one-clock tick every DIV clocks.
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - synchronous active-low reset
//   tick - high during the last clock of each DIV-clock period
module tick_gen
  import counter_mod_pkg::*;
#(
  parameter int DIV = CM_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int          PW    = cm_prescale_width(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;

  // The tick is taken straight from the phase register, so it is high for
  // the whole clock in which the phase sits at its final value.
  assign tick = (p_q == P_LAST);

  // Phase advance: wrap back to zero on the tick clock. With DIV==1 the
  // phase is pinned at zero and the tick never drops.
  always_comb begin
    p_d = p_q + PW'(1);
    if (tick) begin
      p_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/counter_modulo.sv
// Free-running modulo-MOD up-counter gated by a built-in prescaler.
// The count advances once every DIV clocks, wraps from MOD-1 to 0, and is
// used as the step/iteration sequencer for the CORDIC datapath.
// Ports:
//   clk - single clock, all state updates on the rising edge
//   rst - synchronous active-low reset
//   out - current count value (WIDTH bits), driven directly from q
module counter_modulo
  import counter_mod_pkg::*;
#(
  parameter int WIDTH = CM_WIDTH,
  parameter int MOD   = CM_MOD,
  parameter int DIV   = CM_DIV
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
);

  // Parameter sanity: a modulus that cannot be represented, a modulus below
  // two, or a zero prescale ratio stops elaboration.
  if (MOD < 2) begin : g_bad_mod_low
    $error("counter_modulo: MOD must be at least 2");
  end
  if (MOD > (2 ** WIDTH)) begin : g_bad_mod_high
    $error("counter_modulo: MOD does not fit in WIDTH bits");
  end
  if (DIV < 1) begin : g_bad_div
    $error("counter_modulo: DIV must be at least 1");
  end

  localparam logic [WIDTH-1:0] Q_LAST = WIDTH'(MOD - 1);

  logic             del;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_d;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (del)
  );

  // Compare against the last legal value before incrementing, so the wrap
  // never depends on arithmetic overflow; a full-range modulus still lands
  // on zero because the compare fires at the all-ones value.
  always_comb begin
    q_d = q;
    if (del) begin
      q_d = (q == Q_LAST) ? '0 : q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

  assign out = q;

endmodule

// File: tb/tb_counter_modulo.sv
// Directed bench for counter_modulo: default configuration plus a
// divide-by-one/modulo-16 instance and a divide-by-three/modulo-4 instance.
module tb_counter_modulo;
  import counter_mod_pkg::*;

  logic       clk;
  logic       rst;
  logic       rst1;
  logic       rst3;
  cm_count_t  out;
  logic [3:0] out1;
  logic [3:0] out3;

  int compareCount;
  int mismatchCount;

  counter_modulo UUT (
    .clk (clk),
    .rst (rst),
    .out (out)
  );

  counter_modulo #(.WIDTH(4), .MOD(16), .DIV(1)) UUT1 (
    .clk (clk),
    .rst (rst1),
    .out (out1)
  );

  counter_modulo #(.WIDTH(4), .MOD(4), .DIV(3)) UUT3 (
    .clk (clk),
    .rst (rst3),
    .out (out3)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic stepEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset held for three edges after the default counter has wandered off.
  task automatic test_reset();
    rst = 1'b1;
    repeat (7) stepEdge();
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      stepEdge();
      compareCount++;
      if (UUT.q !== 4'd0) begin
        mismatchCount++;
        $display("[TB] FAIL reset_q edge %0d: got %0d, want 0", e, UUT.q);
      end
      compareCount++;
      if (out !== 4'd0) begin
        mismatchCount++;
        $display("[TB] FAIL reset_out edge %0d: got %0d, want 0", e, out);
      end
      compareCount++;
      if (UUT.del !== 1'b0) begin
        mismatchCount++;
        $display("[TB] FAIL reset_del edge %0d: got %0b, want 0", e, UUT.del);
      end
    end
  endtask

  // Count/prescale from release; shared by the mid-run reset scenario.
  task automatic checkCountFromRelease(input string tag);
    int edgeTab [4] = '{1, 2, 4, 10};
    int outTab  [4] = '{0, 1, 2, 5};
    int idx;
    idx = 0;
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      stepEdge();
      if (e == edgeTab[idx]) begin
        compareCount++;
        if (out !== 4'(outTab[idx])) begin
          mismatchCount++;
          $display("[TB] FAIL %s_out edge %0d: got %0d, want %0d", tag, e, out, outTab[idx]);
        end
        if (e == 1) begin
          compareCount++;
          if (UUT.del !== 1'b1) begin
            mismatchCount++;
            $display("[TB] FAIL %s_del edge 1: got %0b, want 1", tag, UUT.del);
          end
        end
        if (idx < 3) idx++;
      end
    end
  endtask

  task automatic test_count();
    checkCountFromRelease("count");
  endtask

  // Twenty edges from release: 9 reached at edge 18, wrap to 0 at edge 20.
  task automatic test_wrap();
    int maxSeen;
    rst = 1'b0;
    stepEdge();
    rst = 1'b1;
    maxSeen = 0;
    for (int e = 1; e <= 20; e++) begin
      stepEdge();
      if (int'(out) > maxSeen) maxSeen = int'(out);
      if (e == 18) begin
        compareCount++;
        if (out !== 4'd9) begin
          mismatchCount++;
          $display("[TB] FAIL wrap_top edge 18: got %0d, want 9", out);
        end
      end
      if (e == 20) begin
        compareCount++;
        if (out !== 4'd0) begin
          mismatchCount++;
          $display("[TB] FAIL wrap_zero edge 20: got %0d, want 0", out);
        end
      end
    end
    compareCount++;
    if (maxSeen > 9) begin
      mismatchCount++;
      $display("[TB] FAIL wrap_max: got %0d, want at most 9", maxSeen);
    end
  endtask

  // Reset dropped while out==6 and a tick is pending.
  task automatic test_mid_reset();
    rst = 1'b0;
    stepEdge();
    rst = 1'b1;
    repeat (13) stepEdge();
    compareCount++;
    if (out !== 4'd6) begin
      mismatchCount++;
      $display("[TB] FAIL midrst_pre_out: got %0d, want 6", out);
    end
    compareCount++;
    if (UUT.del !== 1'b1) begin
      mismatchCount++;
      $display("[TB] FAIL midrst_pre_del: got %0b, want 1", UUT.del);
    end
    rst = 1'b0;
    stepEdge();
    compareCount++;
    if (out !== 4'd0) begin
      mismatchCount++;
      $display("[TB] FAIL midrst_out: got %0d, want 0", out);
    end
    compareCount++;
    if (UUT.u_tick_gen.p_q !== 1'b0) begin
      mismatchCount++;
      $display("[TB] FAIL midrst_p: got %0d, want 0", UUT.u_tick_gen.p_q);
    end
    checkCountFromRelease("restart");
  endtask

  // DIV=1, MOD=16: advances every edge and wraps on the 16th.
  task automatic test_div1();
    rst1 = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      stepEdge();
      compareCount++;
      if (out1 !== 4'(e % 16)) begin
        mismatchCount++;
        $display("[TB] FAIL div1_out edge %0d: got %0d, want %0d", e, out1, e % 16);
      end
      compareCount++;
      if (UUT1.del !== 1'b1) begin
        mismatchCount++;
        $display("[TB] FAIL div1_del edge %0d: got %0b, want 1", e, UUT1.del);
      end
    end
  endtask

  // DIV=3, MOD=4: steps on edges 3, 6, 9, 12.
  task automatic test_div3();
    int edgeTab [5] = '{2, 3, 6, 9, 12};
    int outTab  [5] = '{0, 1, 2, 3, 0};
    int idx;
    idx = 0;
    rst3 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      stepEdge();
      if (e == edgeTab[idx]) begin
        compareCount++;
        if (out3 !== 4'(outTab[idx])) begin
          mismatchCount++;
          $display("[TB] FAIL div3_out edge %0d: got %0d, want %0d", e, out3, outTab[idx]);
        end
        if (idx < 4) idx++;
      end
    end
  endtask

  // Scenario sequence; every instance starts out held in reset.
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst  = 1'b0;
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    stepEdge();
    test_reset();
    test_count();
    test_wrap();
    test_mid_reset();
    test_div1();
    test_div3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
